// File: rtl/bpm_link_pkg.sv
// Shared types for the Aurora BPM TX link scheduler.
// Word width matches the per-source 4-word packet writers.
package bpm_link_pkg;

   localparam int WORD_W     = 32;
   localparam int STAT_STALL = 0;
   localparam int STAT_DROP  = 1;

   typedef enum logic [1:0] {
      ST_ARB     = 2'd0,
      ST_FORWARD = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

endpackage

// File: rtl/bpm_link_arbiter_if.sv
// AXI-Stream bundle between N packet writers and the Aurora TX port.
// master = arbiter view, slave = writers/link view.
interface bpm_link_arbiter_if #(
   parameter int N = 4
);
   import bpm_link_pkg::*;

   logic [WORD_W*N-1:0] s_tdata;
   logic [N-1:0]        s_tvalid;
   logic [N-1:0]        s_tlast;
   logic [N-1:0]        s_tready;
   logic [WORD_W-1:0]   m_tdata;
   logic                m_tvalid;
   logic                m_tlast;
   logic                m_tready;

   modport master (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tdata, m_tvalid, m_tlast
   );

   modport slave (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tvalid, m_tlast
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or after ptr,
// scanning upward with wrap.
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] gnt_idx,
   output logic         any
);

   localparam int WP = W + 1;

   logic [W:0]   sum;
   logic [W-1:0] ix;

   // Descending scan so the closest request to ptr is written last.
   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      sum     = '0;
      ix      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + WP'(k);
         if (sum >= WP'(N)) sum = sum - WP'(N);
         ix = sum[W-1:0];
         if (req[ix]) begin
            gnt_idx = ix;
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bpm_link_arbiter.sv
// Packet-atomic round-robin arbiter for the Aurora BPM TX link with
// per-FA-cycle budget, channel-drop drain and status reporting.
module bpm_link_arbiter
   import bpm_link_pkg::*;
#(
   parameter int NUM_SOURCES     = 4,
   parameter int PKT_COUNT_WIDTH = 6
) (
   input  logic                       auroraUserClk,
   input  logic                       auroraResetN,
   input  logic                       auroraFAstrobe,
   input  logic                       auroraChannelUp,
   input  logic [PKT_COUNT_WIDTH-1:0] maxPackets,
   bpm_link_arbiter_if.master         lnk,
   output logic                       statusStrobe,
   output logic [1:0]                 statusCode,
   output logic [PKT_COUNT_WIDTH-1:0] lastPacketCount,
   output logic [1:0]                 dbgState
);

   localparam int N  = NUM_SOURCES;
   localparam int W  = $clog2(N);
   localparam int CW = PKT_COUNT_WIDTH;

   logic [1:0]        rstPipe;
   logic              rstN;
   state_t            state;
   logic [W-1:0]      grant;
   logic [W-1:0]      rrPtr;
   logic [W-1:0]      nextPtr;
   logic [W-1:0]      pickIdx;
   logic              pickAny;
   logic [CW-1:0]     pktCount;
   logic              stallFlag;
   logic              dropFlag;
   logic              budgetOk;
   logic              canGrant;
   logic              stallEvt;
   logic              fwdLast;
   logic              drainLast;
   logic              selValid;
   logic              selLast;
   logic [WORD_W-1:0] selData;

   // Assert asynchronously, release on the user clock.
   always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
      if (!auroraResetN) rstPipe <= '0;
      else               rstPipe <= {rstPipe[0], 1'b1};
   end

   assign rstN = rstPipe[1];

   rr_pick #(
      .N(N),
      .W(W)
   ) uPick (
      .req    (lnk.s_tvalid),
      .ptr    (rrPtr),
      .gnt_idx(pickIdx),
      .any    (pickAny)
   );

   assign selValid  = lnk.s_tvalid[grant];
   assign selLast   = lnk.s_tlast[grant];
   assign selData   = lnk.s_tdata[int'(grant)*WORD_W +: WORD_W];
   assign nextPtr   = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
   assign budgetOk  = pktCount < maxPackets;
   assign dbgState  = state;

   assign canGrant  = (state == ST_ARB) && auroraChannelUp
                    && pickAny && budgetOk;
   assign stallEvt  = (state == ST_ARB) && (|lnk.s_tvalid) && !budgetOk;
   assign fwdLast   = (state == ST_FORWARD) && auroraChannelUp
                    && selValid && lnk.m_tready && selLast;
   assign drainLast = (state == ST_DRAIN) && selValid && selLast;

   // A channel drop masks the granted beat in the same cycle.
   always_comb begin
      lnk.m_tdata  = '0;
      lnk.m_tvalid = 1'b0;
      lnk.m_tlast  = 1'b0;
      lnk.s_tready = '0;
      unique case (1'b1)
         (state == ST_FORWARD): begin
            if (auroraChannelUp) begin
               lnk.m_tdata         = selData;
               lnk.m_tvalid        = selValid;
               lnk.m_tlast         = selLast;
               lnk.s_tready[grant] = lnk.m_tready;
            end
         end
         (state == ST_DRAIN): lnk.s_tready[grant] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge auroraUserClk or negedge rstN) begin
      if (!rstN) begin
         state           <= ST_ARB;
         grant           <= '0;
         rrPtr           <= '0;
         pktCount        <= '0;
         stallFlag       <= 1'b0;
         dropFlag        <= 1'b0;
         statusStrobe    <= 1'b0;
         statusCode      <= '0;
         lastPacketCount <= '0;
      end else begin
         unique case (state)
            ST_ARB: begin
               if (canGrant) begin
                  grant <= pickIdx;
                  state <= ST_FORWARD;
               end
            end
            ST_FORWARD: begin
               if (!auroraChannelUp) begin
                  state <= ST_DRAIN;
               end else if (fwdLast) begin
                  rrPtr <= nextPtr;
                  state <= ST_ARB;
               end
            end
            ST_DRAIN: begin
               if (drainLast) begin
                  rrPtr <= nextPtr;
                  state <= ST_ARB;
               end
            end
            default: state <= ST_ARB;
         endcase

         statusStrobe <= auroraFAstrobe;
         // Events in the strobe cycle belong to the new FA cycle.
         if (auroraFAstrobe) begin
            statusCode[STAT_STALL] <= stallFlag;
            statusCode[STAT_DROP]  <= dropFlag;
            lastPacketCount        <= pktCount;
            pktCount               <= CW'(fwdLast);
            stallFlag              <= stallEvt;
            dropFlag               <= drainLast;
         end else begin
            if (fwdLast && ~&pktCount) pktCount <= pktCount + 1'b1;
            if (stallEvt)  stallFlag <= 1'b1;
            if (drainLast) dropFlag  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bpm_link_arbiter.sv
// Scoreboard bench: sources emit tagged 4-word packets, expected stream
// is queued in round-robin order and checked by an independent monitor.
module tb_bpm_link_arbiter;

   logic       auroraUserClk = 1'b0;
   logic       auroraResetN;
   logic       auroraFAstrobe;
   logic       auroraChannelUp;
   logic [5:0] maxPackets;
   logic       statusStrobe;
   logic [1:0] statusCode;
   logic [5:0] lastPacketCount;
   logic [1:0] dbgState;

   bpm_link_arbiter_if #(.N(4)) lnk ();

   bpm_link_arbiter #(
      .NUM_SOURCES(4),
      .PKT_COUNT_WIDTH(6)
   ) dut (
      .auroraUserClk  (auroraUserClk),
      .auroraResetN   (auroraResetN),
      .auroraFAstrobe (auroraFAstrobe),
      .auroraChannelUp(auroraChannelUp),
      .maxPackets     (maxPackets),
      .lnk            (lnk),
      .statusStrobe   (statusStrobe),
      .statusCode     (statusCode),
      .lastPacketCount(lastPacketCount),
      .dbgState       (dbgState)
   );

   always #5 auroraUserClk = ~auroraUserClk;

   int          nPass = 0;
   int          nTot  = 0;
   int          srcPkt[4];
   int          srcWord[4];
   int          srcLim[4];
   logic [3:0]  srcEn;
   bit          gapOn;
   bit          rdyRand;
   logic [32:0] expQ[$];
   int          tlastCyc[$];
   int          beatCnt;
   int          cyc = 0;
   logic [1:0]  expCode;

   task automatic chk(input bit ok, input string nm,
                      input longint act, input longint exp);
      nTot++;
      if (ok) nPass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [31:0] wordOf(int s, int k, int w);
      return {4'(s), 20'(k), 8'(w)};
   endfunction

   task automatic pushPkt(int s, int k);
      for (int w = 0; w < 4; w++) expQ.push_back({w == 3, wordOf(s, k, w)});
   endtask

   // Source model: AXI-legal, valid held until accepted.
   initial begin : driver
      bit hs[4];
      bit v;
      forever begin
         @(negedge auroraUserClk);
         for (int i = 0; i < 4; i++) hs[i] = lnk.s_tvalid[i] && lnk.s_tready[i];
         @(posedge auroraUserClk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (!auroraResetN) begin
               srcPkt[i]  = 0;
               srcWord[i] = 0;
            end else if (hs[i]) begin
               srcWord[i] = (srcWord[i] + 1) % 4;
               if (srcWord[i] == 0) srcPkt[i]++;
            end
            if (!(srcEn[i] && srcPkt[i] < srcLim[i])) v = 1'b0;
            else if (lnk.s_tvalid[i] && !hs[i] && auroraResetN) v = 1'b1;
            else v = (srcWord[i] == 0) || !gapOn || ($urandom_range(3) != 0);
            lnk.s_tvalid[i]         = v;
            lnk.s_tlast[i]          = (srcWord[i] == 3);
            lnk.s_tdata[32*i +: 32] = wordOf(i, srcPkt[i], srcWord[i]);
         end
         lnk.m_tready = rdyRand ? ($urandom_range(3) != 0) : 1'b1;
      end
   end

   // Monitor: stream scoreboard, AXI stability, FA-window packet count.
   initial begin : monitor
      bit          strobePrev = 0;
      bit          prevStall  = 0;
      logic [32:0] prevBeat   = '0;
      logic [32:0] exp;
      int          winCnt     = 0;
      int          expCnt     = 0;
      bit          tl;
      forever begin
         @(negedge auroraUserClk);
         cyc++;
         if (!auroraResetN) begin
            winCnt     = 0;
            strobePrev = 0;
            prevStall  = 0;
         end else begin
            if (strobePrev || statusStrobe) begin
               chk(statusStrobe == strobePrev, "statusStrobe",
                   statusStrobe, strobePrev);
               if (strobePrev) begin
                  chk(int'(lastPacketCount) == expCnt, "lastPacketCount",
                      lastPacketCount, expCnt);
                  chk(statusCode == expCode, "statusCode", statusCode, expCode);
               end
            end
            if (prevStall && auroraChannelUp)
               chk(lnk.m_tvalid && {lnk.m_tlast, lnk.m_tdata} == prevBeat,
                   "stallStable", {lnk.m_tvalid, lnk.m_tlast, lnk.m_tdata},
                   {1'b1, prevBeat});
            tl = 0;
            if (lnk.m_tvalid && lnk.m_tready) begin
               if (expQ.size() == 0) begin
                  chk(0, "unexpectedBeat", lnk.m_tdata, 0);
               end else begin
                  exp = expQ.pop_front();
                  chk({lnk.m_tlast, lnk.m_tdata} == exp, "beat",
                      {lnk.m_tlast, lnk.m_tdata}, exp);
               end
               beatCnt++;
               tl = lnk.m_tlast;
               if (tl) tlastCyc.push_back(cyc);
            end
            if (auroraFAstrobe) begin
               expCnt = winCnt;
               winCnt = int'(tl);
            end else begin
               winCnt += int'(tl);
            end
            strobePrev = auroraFAstrobe;
            prevStall  = lnk.m_tvalid && !lnk.m_tready && auroraChannelUp;
            prevBeat   = {lnk.m_tlast, lnk.m_tdata};
         end
      end
   end

   task automatic startTest(int maxP, logic [3:0] en, int lim,
                            bit gap, bit rr);
      auroraResetN = 1'b0;
      expQ.delete();
      tlastCyc.delete();
      beatCnt         = 0;
      maxPackets      = 6'(maxP);
      srcEn           = en;
      gapOn           = gap;
      rdyRand         = rr;
      auroraChannelUp = 1'b1;
      expCode         = 2'd0;
      for (int i = 0; i < 4; i++) srcLim[i] = lim;
      repeat (3) @(posedge auroraUserClk);
      #1 auroraResetN = 1'b1;
      @(posedge auroraUserClk);
      #1;
   endtask

   task automatic pulseStrobe();
      @(posedge auroraUserClk);
      #1 auroraFAstrobe = 1'b1;
      @(posedge auroraUserClk);
      #1 auroraFAstrobe = 1'b0;
      repeat (2) @(negedge auroraUserClk);
   endtask

   task automatic waitEmpty(string nm, int bound);
      for (int i = 0; i < bound && expQ.size() != 0; i++) begin
         @(negedge auroraUserClk);
         #1;
      end
      chk(expQ.size() == 0, nm, expQ.size(), 0);
   endtask

   task automatic waitBeats(string nm, int n);
      for (int i = 0; i < 100 && beatCnt < n; i++) begin
         @(negedge auroraUserClk);
         #1;
      end
      chk(beatCnt == n, nm, beatCnt, n);
   endtask

   initial begin : main
      bit ok;
      int t;
      auroraResetN    = 1'b1;
      auroraFAstrobe  = 1'b0;
      auroraChannelUp = 1'b1;
      maxPackets      = 6'd32;
      srcEn           = '0;
      gapOn           = 0;
      rdyRand         = 0;
      expCode         = 2'd0;
      beatCnt         = 0;
      for (int i = 0; i < 4; i++) srcLim[i] = 0;
      lnk.m_tready = 1'b1;
      lnk.s_tvalid = '0;
      lnk.s_tlast  = '0;
      lnk.s_tdata  = '0;
      #1 auroraResetN = 1'b0;
      #1;
      chk(!lnk.m_tvalid && lnk.s_tready == 0 && !statusStrobe
          && statusCode == 0 && lastPacketCount == 0 && dbgState == 0
          && lnk.m_tdata == 0 && !lnk.m_tlast, "resetOutputs",
          {lnk.m_tvalid, lnk.s_tready, dbgState, lastPacketCount}, 0);

      // Round-robin, full throughput, 5 cycles per packet.
      startTest(32, 4'b1111, 2, 0, 0);
      for (int p = 0; p < 8; p++) pushPkt(p % 4, p / 4);
      waitEmpty("rrOrder", 200);
      chk(tlastCyc.size() == 8, "rrPktCount", tlastCyc.size(), 8);
      ok = (tlastCyc.size() == 8);
      for (int i = 1; i < tlastCyc.size(); i++)
         if (tlastCyc[i] - tlastCyc[i-1] != 5) ok = 0;
      chk(ok, "pktPeriod5", ok, 1);
      pulseStrobe();

      // Budget of 3 with sources 0 and 2.
      startTest(3, 4'b0101, 100, 0, 0);
      pushPkt(0, 0);
      pushPkt(2, 0);
      pushPkt(0, 1);
      waitEmpty("budgetPkts", 100);
      ok = 1;
      repeat (10) begin
         @(negedge auroraUserClk);
         if (lnk.s_tready != 0 || lnk.m_tvalid || dbgState != 0) ok = 0;
      end
      chk(ok, "budgetBlocks", lnk.s_tready, 0);
      pushPkt(2, 1);
      pushPkt(0, 2);
      pushPkt(2, 2);
      expCode = 2'd1;
      pulseStrobe();
      waitEmpty("budgetResume", 100);

      // Channel drop after two words of a source-1 packet.
      startTest(32, 4'b0010, 1, 0, 0);
      expQ.push_back({1'b0, wordOf(1, 0, 0)});
      expQ.push_back({1'b0, wordOf(1, 0, 1)});
      waitBeats("dropBeats", 2);
      @(posedge auroraUserClk);
      #1 auroraChannelUp = 1'b0;
      @(negedge auroraUserClk);
      chk(!lnk.m_tvalid, "dropNoFwd", lnk.m_tvalid, 0);
      @(negedge auroraUserClk);
      chk(lnk.s_tready == 4'b0010 && !lnk.m_tvalid, "drainReady1",
          {lnk.m_tvalid, lnk.s_tready}, 4'b0010);
      @(negedge auroraUserClk);
      chk(lnk.s_tready == 4'b0010 && !lnk.m_tvalid, "drainReady2",
          {lnk.m_tvalid, lnk.s_tready}, 4'b0010);
      @(negedge auroraUserClk);
      chk(srcPkt[1] == 1 && lnk.s_tready == 0, "drainDone",
          {srcPkt[1], lnk.s_tready}, 64'h100000000);
      @(posedge auroraUserClk);
      #1 auroraChannelUp = 1'b1;
      expCode = 2'd2;
      pulseStrobe();

      // FA strobe coincident with a tlast handshake.
      startTest(32, 4'b0001, 3, 0, 0);
      for (int k = 0; k < 3; k++) pushPkt(0, k);
      waitBeats("pkt2Start", 5);
      repeat (3) @(posedge auroraUserClk);
      #1 auroraFAstrobe = 1'b1;
      @(posedge auroraUserClk);
      #1 auroraFAstrobe = 1'b0;
      @(negedge auroraUserClk);
      chk(statusStrobe, "strobeT1", statusStrobe, 1);
      chk(lastPacketCount == 1, "tlastExcluded", lastPacketCount, 1);
      @(negedge auroraUserClk);
      chk(!statusStrobe, "strobeOnce", statusStrobe, 0);
      waitEmpty("strobePkts", 100);
      pulseStrobe();
      chk(lastPacketCount == 2, "newCycleCount", lastPacketCount, 2);

      // Random back-pressure and source gaps over 1000 packets.
      startTest(32, 4'b1111, 250, 1, 1);
      for (int p = 0; p < 1000; p++) pushPkt(p % 4, p / 4);
      t = 0;
      while (expQ.size() != 0 && t < 40000) begin
         @(posedge auroraUserClk);
         #1 auroraFAstrobe = (t % 37 == 36);
         t++;
      end
      #1 auroraFAstrobe = 1'b0;
      chk(expQ.size() == 0, "random1000", expQ.size(), 0);
      pulseStrobe();

      // Asynchronous reset in the middle of a packet.
      startTest(32, 4'b1111, 100, 0, 0);
      pushPkt(0, 0);
      waitBeats("preResetBeats", 2);
      #2 auroraResetN = 1'b0;
      #1;
      chk(!lnk.m_tvalid && lnk.s_tready == 0 && !lnk.m_tlast
          && lnk.m_tdata == 0 && dbgState == 0 && !statusStrobe
          && statusCode == 0 && lastPacketCount == 0, "asyncReset",
          {lnk.m_tvalid, lnk.s_tready, dbgState}, 0);
      expQ.delete();
      for (int i = 0; i < 4; i++) srcLim[i] = 1;
      for (int s = 0; s < 4; s++) pushPkt(s, 0);
      repeat (3) @(posedge auroraUserClk);
      #1 auroraResetN = 1'b1;
      waitEmpty("firstGrantSrc0", 100);

      $display("%0d/%0d checks passed", nPass, nTot);
      $finish;
   end

endmodule

// File: doc/bpm_link_arbiter.md
# bpm_link_arbiter

Packet-atomic round-robin arbiter sharing one Aurora BPM TX AXI-Stream link among `NUM_SOURCES` packet generators (test-pattern writers, live BPM forwarders). Sits between the per-source 4-word packet writers (header, X, Y, sum; `tlast` on sum) and the Aurora TX port. Enforces a per-FA-cycle packet budget, drains in-flight packets when the channel drops, and reports a status code once per FA strobe.

## Interface
- `NUM_SOURCES`, 4: number of requesting streams (2..8).
- `PKT_COUNT_WIDTH`, 6: width of packet budget and counters.
- `auroraUserClk` in 1: single clock, Aurora user clock domain.
- `auroraResetN` in 1: asynchronous, active-low reset.
- `auroraFAstrobe` in 1: one-cycle marker, start of FA cycle.
- `auroraChannelUp` in 1: Aurora channel status.
- `maxPackets` in `PKT_COUNT_WIDTH`: packets allowed per FA cycle (quasi-static).
- `s_tdata` in 32*N: source data, source i at `[32*i+:32]`.
- `s_tvalid`, `s_tlast` in N; `s_tready` out N.
- `m_tdata` out 32; `m_tvalid`, `m_tlast` out 1; `m_tready` in 1.
- `statusStrobe` out 1: one-cycle pulse after each FA strobe.
- `statusCode` out 2: bit0 budget stall, bit1 packet dropped.
- `lastPacketCount` out `PKT_COUNT_WIDTH`: packets forwarded in the closed cycle.
- `dbgState` out 2: current state.

## Operation
- States: `ST_ARB`=0, `ST_FORWARD`=1, `ST_DRAIN`=2.
- `ST_ARB`: all `s_tready`=0, `m_tvalid`=0. Grant when `auroraChannelUp` && any `s_tvalid` && `pktCount < maxPackets`. Pick the first valid source at or after `rrPtr`, scanning upward with wrap. Latch `grant`, go to `ST_FORWARD`.
- `ST_FORWARD`: `m_tdata/m_tvalid/m_tlast` = source `grant` combinationally. `s_tready[grant]` = `m_tready`; other `s_tready`=0.
  - Beat completes on `tvalid && tready`.
  - On the `tlast` beat: `pktCount`++, `rrPtr` = (grant+1) mod N, go to `ST_ARB`.
- `auroraChannelUp` low in `ST_FORWARD` has priority over the beat. Go to `ST_DRAIN` that cycle; the beat is not forwarded.
- `ST_DRAIN`: `m_tvalid`=0; `s_tready[grant]`=1. Discard beats until a `tlast` beat, then set `dropFlag`, advance `rrPtr`, go to `ST_ARB`. The dropped packet is not counted.
- Budget: at `ST_ARB` with `pktCount == maxPackets` and any `s_tvalid`, set `stallFlag`. Sources are back-pressured, never dropped. `maxPackets`=0 blocks all grants.
- FA strobe (cycle T):
  - Cycle T+1: `statusStrobe`=1, `statusCode`={dropFlag, stallFlag}, `lastPacketCount`=`pktCount` as of T.
  - Flags and `pktCount` clear at T+1.
  - A `tlast` completing in cycle T counts toward the new cycle, so `pktCount`=1 at T+1.
  - The strobe never interrupts an in-flight packet.
- `pktCount` saturates at all-ones.

## Timing
- Reset values: all outputs 0, state `ST_ARB`, `rrPtr`=0, counters and flags 0.
- Arbitration bubble of one cycle per packet; first `m_tvalid` one cycle after grant.
- Data path is combinational from `s_*` to `m_*`; no added latency within a packet.
- Holding `m_tready`=1 gives a 4-word packet 5 cycles (1 ARB + 4 data).
- AXI rules:
  - `m_tvalid` never deasserts without a handshake inside `ST_FORWARD`, unless the channel drops.
  - `m_tdata` is stable while stalled, provided the source obeys AXI.
- Reset mid-packet drops all readies immediately (asynchronous assert). Deassertion is synchronized to `auroraUserClk`.

## Structure
- Package `bpm_link_pkg`: state encodings, status bit indices (`STAT_STALL`=0, `STAT_DROP`=1), and the 32-bit word width constant shared with the packet writers.
- Sub-module `rr_pick`: combinational round-robin priority picker (`req[N]`, `ptr`) → (`gnt_idx`, `any`). Reusable by other link schedulers.
- Top contains the FSM, counters, flags and output mux.

## Test plan
- N=4, all sources valid with 4-word packets, `m_tready`=1, `maxPackets`=32 → grants 0,1,2,3,0…; each packet takes 5 cycles; `lastPacketCount` at the next strobe equals packets sent; code 0.
- `maxPackets`=3, sources 0 and 2 continuously valid → exactly 3 packets (0,2,0); then all `s_tready` stay 0; next strobe gives code 1 and count 3; forwarding resumes with source 2.
- Channel drops after word 2 of a source-1 packet → no further `m_tvalid`; `s_tready[1]` held 1 until `tlast`; strobe gives code 2; packet not counted.
- FA strobe in the same cycle as a `tlast` handshake → `lastPacketCount` excludes it; new `pktCount`=1; `statusStrobe` exactly one cycle, at T+1.
- Random `m_tready` back-pressure on 1000 packets → scoreboard shows the output stream equals the concatenated source packets in round-robin order, with no `m_tdata` change while `m_tvalid && !m_tready`.
- `auroraResetN` asserted mid-packet → all outputs 0 asynchronously; after release, state `ST_ARB`, `rrPtr`=0, first grant goes to source 0.
